// File: rtl/bus_reg_file.sv
// Bank of 2**ADDR_W registers loaded from the data bus, with inc/dec/clear counter ops and a
// carry/borrow flag. Define BUS_REG_FILE_BYPASS_EN for same-cycle write-through on the read port.
module bus_reg_file #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  bus_in,
   input  logic              in_use,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        cnt_op,
   input  logic [ADDR_W-1:0] cnt_addr,
   input  logic              out_use,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  out0,
   output logic              carry,
   output logic              zero,
   output logic [WIDTH-1:0]  d,
   output logic [WIDTH-1:0]  q
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             carry_q, carry_d;
   logic             cnt_en;
   logic [WIDTH-1:0] cnt_old;
   logic [WIDTH-1:0] rd_val;

   assign cnt_old = regs_q[cnt_addr];
   // A load to the same register wins; the counter op (and its carry update) is dropped.
   assign cnt_en  = (cnt_op != 2'b00) && !(in_use && (wr_addr == cnt_addr));

   always_comb begin
      regs_d  = regs_q;
      carry_d = carry_q;
      if (cnt_en) begin
         case (cnt_op)
            2'b01: begin
               regs_d[cnt_addr] = cnt_old + One;
               carry_d          = &cnt_old;
            end
            2'b10: begin
               regs_d[cnt_addr] = cnt_old - One;
               carry_d          = ~|cnt_old;
            end
            default: begin
               regs_d[cnt_addr] = '0;
               carry_d          = 1'b0;
            end
         endcase
      end
      if (in_use) begin
         regs_d[wr_addr] = bus_in;
      end
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = '0;
         end
         carry_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         carry_q <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         carry_q <= carry_d;
      end
   end

`ifdef BUS_REG_FILE_BYPASS_EN
   assign rd_val = (in_use && out_use && (wr_addr == rd_addr)) ? bus_in : regs_q[rd_addr];
`else
   assign rd_val = regs_q[rd_addr];
`endif

   assign q     = rd_val;
   assign zero  = (rd_val == '0);
   assign out0  = out_use ? rd_val : '0;
   assign d     = regs_d[rd_addr];
   assign carry = carry_q;

endmodule

// File: tb/tb_bus_reg_file.sv
// Directed self-checking bench for bus_reg_file (WIDTH=8, ADDR_W=2).
module tb_bus_reg_file;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] bus_in;
   logic       in_use;
   logic [1:0] wr_addr;
   logic [1:0] cnt_op;
   logic [1:0] cnt_addr;
   logic       out_use;
   logic [1:0] rd_addr;
   logic [7:0] out0;
   logic       carry;
   logic       zero;
   logic [7:0] d;
   logic [7:0] q;

   int n_checks = 0;
   int n_pass   = 0;

   bus_reg_file #(.WIDTH(8), .ADDR_W(2)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus_in   (bus_in),
      .in_use   (in_use),
      .wr_addr  (wr_addr),
      .cnt_op   (cnt_op),
      .cnt_addr (cnt_addr),
      .out_use  (out_use),
      .rd_addr  (rd_addr),
      .out0     (out0),
      .carry    (carry),
      .zero     (zero),
      .d        (d),
      .q        (q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] rdw_exp;
      reset = 1'b1; bus_in = '0; in_use = 1'b0; wr_addr = '0;
      cnt_op = 2'b00; cnt_addr = '0; out_use = 1'b0; rd_addr = '0;
      tick();
      check("d_in_reset", d, 8'h00);
      tick();
      reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         out_use = i[0];
         #1;
         check("rst_q", q, 8'h00);
         check("rst_zero", zero, 1);
         check("rst_carry", carry, 0);
         check("rst_out0", out0, 8'h00);
      end

      // Load A5 into reg1
      in_use = 1'b1; wr_addr = 2'd1; bus_in = 8'hA5; out_use = 1'b1; rd_addr = 2'd1;
      tick();
      in_use = 1'b0;
      #1;
      check("ld_out0", out0, 8'hA5);
      check("ld_zero", zero, 0);
      out_use = 1'b0;
      #1;
      check("ld_out0_off", out0, 8'h00);
      check("ld_q_off", q, 8'hA5);

      // reg2: FF, inc wraps, dec borrows, dec again
      in_use = 1'b1; wr_addr = 2'd2; bus_in = 8'hFF; rd_addr = 2'd2;
      tick();
      in_use = 1'b0; cnt_op = 2'b01; cnt_addr = 2'd2;
      #1;
      check("inc_d", d, 8'h00);
      tick();
      cnt_op = 2'b00;
      #1;
      check("inc_q", q, 8'h00);
      check("inc_carry", carry, 1);
      check("inc_zero", zero, 1);
      cnt_op = 2'b10;
      tick();
      check("dec_q", q, 8'hFF);
      check("dec_carry", carry, 1);
      tick();
      cnt_op = 2'b00;
      #1;
      check("dec2_q", q, 8'hFE);
      check("dec2_carry", carry, 0);

      // reg3 -> FF (carry 1), then inc reg0 (0->1) drops carry to 0
      cnt_op = 2'b10; cnt_addr = 2'd3;
      tick();
      cnt_op = 2'b01; cnt_addr = 2'd0;
      tick();
      cnt_op = 2'b00; rd_addr = 2'd3;
      #1;
      check("pre_q3", q, 8'hFF);
      check("pre_carry", carry, 0);

      // Load and inc on the same register: load wins, carry holds
      in_use = 1'b1; wr_addr = 2'd3; bus_in = 8'h10; cnt_op = 2'b01; cnt_addr = 2'd3;
      tick();
      in_use = 1'b0; cnt_op = 2'b00;
      #1;
      check("same_q3", q, 8'h10);
      check("same_carry", carry, 0);

      // Load reg0 and inc reg3 together: both apply
      in_use = 1'b1; wr_addr = 2'd0; bus_in = 8'h10; cnt_op = 2'b01; cnt_addr = 2'd3;
      tick();
      in_use = 1'b0; cnt_op = 2'b00;
      rd_addr = 2'd0;
      #1;
      check("diff_q0", q, 8'h10);
      rd_addr = 2'd3;
      #1;
      check("diff_q3", q, 8'h11);

      // Clear reg3
      cnt_op = 2'b11; cnt_addr = 2'd3;
      tick();
      cnt_op = 2'b00;
      #1;
      check("clr_q3", q, 8'h00);
      check("clr_carry", carry, 0);

      // Read-during-write on reg0
      in_use = 1'b1; wr_addr = 2'd0; bus_in = 8'h33;
      tick();
      bus_in = 8'h44; rd_addr = 2'd0; out_use = 1'b1;
`ifdef BUS_REG_FILE_BYPASS_EN
      rdw_exp = 8'h44;
`else
      rdw_exp = 8'h33;
`endif
      #1;
      check("rdw_q", q, rdw_exp);
      check("rdw_out0", out0, rdw_exp);
      check("rdw_d", d, 8'h44);
      tick();
      in_use = 1'b0;
      #1;
      check("rdw_after_q", q, 8'h44);

      // reg2 FE->FF, then load reg1=07 while reg2 wraps (carry 1)
      cnt_op = 2'b01; cnt_addr = 2'd2;
      tick();
      in_use = 1'b1; wr_addr = 2'd1; bus_in = 8'h07;
      tick();
      in_use = 1'b0; cnt_op = 2'b00; rd_addr = 2'd1;
      #1;
      check("pre_rst_q1", q, 8'h07);
      check("pre_rst_carry", carry, 1);

      // Reset with a pending inc on reg1
      reset = 1'b1; cnt_op = 2'b01; cnt_addr = 2'd1;
      #1;
      check("rst_mid_d", d, 8'h00);
      tick();
      reset = 1'b0; cnt_op = 2'b00;
      #1;
      check("rst_mid_q1", q, 8'h00);
      check("rst_mid_carry", carry, 0);
      rd_addr = 2'd2;
      #1;
      check("rst_mid_q2", q, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
